// File: rtl/gauge_needle_ctrl_if.sv
// Bus between the RPM/gear logic (master) and the needle controller (slave).
interface gauge_needle_ctrl_if;
  logic [3:0] speed_level;
  logic [3:0] max_level;
  logic       sweep_start;
  logic       freeze;
  logic [7:0] pos;
  logic [7:0] target;
  logic       r_ctrl;
  logic       l_ctrl;
  logic       busy;
  logic       redline;

  modport master (
    output speed_level, max_level, sweep_start, freeze,
    input  pos, target, r_ctrl, l_ctrl, busy, redline
  );

  modport slave (
    input  speed_level, max_level, sweep_start, freeze,
    output pos, target, r_ctrl, l_ctrl, busy, redline
  );
endinterface

// File: rtl/gauge_needle_ctrl.sv
// Gauge needle controller: power-on / on-demand self-test sweep, then
// one-unit-per-tick tracking of a scaled RPM target with step pulses
// for the downstream servo stage.
module gauge_needle_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int POS_MAX    = 180,
  parameter int SWEEP_HOLD = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  gauge_needle_ctrl_if.slave bus
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  POS_MAX8  = 8'(POS_MAX);
  localparam logic [7:0]  HOLD_LAST = 8'(SWEEP_HOLD - 1);

  typedef enum logic [1:0] {
    ST_SWEEP_UP,
    ST_SWEEP_HOLD,
    ST_SWEEP_DOWN,
    ST_TRACK
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  target_q, target_d;
  logic        r_q, r_d;
  logic        l_q, l_d;
  logic        redline_q, redline_d;

  logic        step;
  logic [11:0] prod;
  logic [11:0] divisor;
  logic        at_or_over;

  assign step       = (tick_q == TICK_LAST);
  assign at_or_over = (bus.speed_level >= bus.max_level);

  // Free-running step-tick divider; never paused, not even by freeze.
  always_comb begin
    tick_d = step ? 16'd0 : tick_q + 16'd1;
  end

  // Scale speed to needle units; full 12-bit product keeps the divide exact.
  // Divisor forced non-zero so the unused branch never divides by zero.
  always_comb begin
    prod    = 12'(bus.speed_level) * 12'(POS_MAX);
    divisor = {8'd0, (bus.max_level == 4'd0) ? 4'd1 : bus.max_level};
    if (bus.max_level == 4'd0)
      target_d = 8'd0;
    else if (at_or_over)
      target_d = POS_MAX8;
    else
      target_d = 8'(prod / divisor);
  end

  // Next-state, needle motion and step pulses.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    r_d     = 1'b0;
    l_d     = 1'b0;
    case (state_q)
      ST_SWEEP_UP: begin
        if (step) begin
          if (pos_q >= POS_MAX8) begin
            // Sweep requested while already at full scale: go straight to dwell.
            state_d = ST_SWEEP_HOLD;
            hold_d  = 8'd0;
          end else begin
            pos_d = pos_q + 8'd1;
            r_d   = 1'b1;
            if (pos_q + 8'd1 == POS_MAX8) begin
              state_d = ST_SWEEP_HOLD;
              hold_d  = 8'd0;
            end
          end
        end
      end
      ST_SWEEP_HOLD: begin
        if (step) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_SWEEP_DOWN;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_SWEEP_DOWN: begin
        if (step) begin
          if (pos_q == 8'd0) begin
            state_d = ST_TRACK;
          end else begin
            pos_d = pos_q - 8'd1;
            l_d   = 1'b1;
            if (pos_q == 8'd1) state_d = ST_TRACK;
          end
        end
      end
      default: begin
        // Sweep request wins over any motion due on the same cycle.
        if (bus.sweep_start) begin
          state_d = ST_SWEEP_UP;
        end else if (step && !bus.freeze) begin
          if (pos_q < target_q) begin
            pos_d = pos_q + 8'd1;
            r_d   = 1'b1;
          end else if (pos_q > target_q) begin
            pos_d = pos_q - 8'd1;
            l_d   = 1'b1;
          end
        end
      end
    endcase
  end

  // Redline keyed on the next state so it is never seen high in a sweep state.
  always_comb begin
    redline_d = (state_d == ST_TRACK) && (bus.max_level != 4'd0) && at_or_over;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SWEEP_UP;
      tick_q    <= 16'd0;
      hold_q    <= 8'd0;
      pos_q     <= 8'd0;
      target_q  <= 8'd0;
      r_q       <= 1'b0;
      l_q       <= 1'b0;
      redline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      pos_q     <= pos_d;
      target_q  <= target_d;
      r_q       <= r_d;
      l_q       <= l_d;
      redline_q <= redline_d;
    end
  end

  assign bus.pos     = pos_q;
  assign bus.target  = target_q;
  assign bus.r_ctrl  = r_q;
  assign bus.l_ctrl  = l_q;
  assign bus.redline = redline_q;
  assign bus.busy    = (state_q != ST_TRACK);

endmodule
